// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
package div_mon_pkg;

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} mon_state_t;

    localparam int ERR_W         = 8;
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain for an asynchronous level, with the synchronized level
// and single-cycle rise/fall strobes.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // The previous-value flop sits after the chain so that rise/fall compare
    // two fully synchronized samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                chain[i] <= chain[i-1];
            end
            chain[0] <= d;
            prev     <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/div_ratio_monitor.sv
// Measures period and high time of a divided clock in source-clock cycles,
// locks on a run of matching periods and flags ratio/duty errors and stalls.
module div_ratio_monitor
    import div_mon_pkg::*;
#(
    parameter int EXP_DIV     = 3,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             stuck,
    output logic [ERR_W-1:0] err_count
);

    localparam int               RUN_W       = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   EXT_ONE     = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0] EXP_CNT     = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_ONE     = RUN_W'(1);
    localparam logic [RUN_W-1:0] LOCK_RUN    = RUN_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    logic level, rise, unused_fall;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (div_in),
        .level (level),
        .rise  (rise),
        .fall  (unused_fall)
    );

    mon_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, hcnt, meas;
    logic [RUN_W-1:0] run, run_next;
    logic [CNT_W:0]   twice_high, meas_ext;
    logic             capture, match, duty_ok, timeout_hit, err_inc;

    // Duty tolerance of one cycle absorbs sampling skew on odd ratios.
    assign meas       = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    assign twice_high = {hcnt, 1'b0};
    assign meas_ext   = {1'b0, meas};
    assign duty_ok    = (twice_high == meas_ext) ||
                        (twice_high == meas_ext + EXT_ONE) ||
                        (twice_high + EXT_ONE == meas_ext);
    assign match      = (meas == EXP_CNT) && duty_ok;

    // A rise always takes priority over a coincident timeout.
    always_comb begin
        state_next  = state;
        run_next    = run;
        capture     = 1'b0;
        err_inc     = 1'b0;
        timeout_hit = 1'b0;
        if (rise) begin
            case (state)
                IDLE: begin
                    state_next = ACQ;
                    run_next   = '0;
                end
                ACQ: begin
                    capture = 1'b1;
                    if (!match) begin
                        run_next = '0;
                    end else if (run + RUN_ONE == LOCK_RUN) begin
                        state_next = LOCKED;
                        run_next   = '0;
                    end else begin
                        run_next = run + RUN_ONE;
                    end
                end
                LOCKED: begin
                    capture = 1'b1;
                    if (!match) begin
                        err_inc    = 1'b1;
                        state_next = ACQ;
                        run_next   = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (cnt == TIMEOUT_CNT && !stuck) begin
            timeout_hit = 1'b1;
            err_inc     = (state == LOCKED);
            state_next  = IDLE;
            run_next    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            run        <= '0;
            cnt        <= '0;
            hcnt       <= '0;
            period_o   <= '0;
            high_o     <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            stuck      <= 1'b0;
            err_count  <= '0;
        end else begin
            state <= state_next;
            run   <= run_next;

            if (rise) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (rise) begin
                hcnt <= CNT_ONE;
            end else if (level && hcnt != CNT_MAX) begin
                hcnt <= hcnt + CNT_ONE;
            end

            meas_valid <= capture;
            if (capture) begin
                period_o <= meas;
                high_o   <= hcnt;
            end

            // locked follows the state register, so it lags entry and exit by one cycle.
            locked    <= (state == LOCKED);
            err_pulse <= err_inc;

            if (rise) begin
                stuck <= 1'b0;
            end else if (timeout_hit) begin
                stuck <= 1'b1;
            end

            if (clr_err) begin
                err_count <= '0;
            end else if (err_inc && err_count != ERR_MAX) begin
                err_count <= err_count + ERR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_div_ratio_monitor.sv
// Directed bench for div_ratio_monitor: lock, ratio error, stall, error clear,
// non-matching duty at ratio 4 and asynchronous reset while locked.
module tb_div_ratio_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_err;
    logic        div3, div4;
    logic [15:0] period3, high3, period4, high4;
    logic        meas_valid3, locked3, err_pulse3, stuck3;
    logic        meas_valid4, locked4, err_pulse4, stuck4;
    logic [7:0]  err_count3, err_count4;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit gen_on = 0;
    int shot_req = 0, shot_done = 0, shot_hi = 2, shot_lo = 2;
    int rise_count = 0, last_rise_edge = 0;
    bit locked4_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (locked4) locked4_seen <= 1'b1;

    div_ratio_monitor #(.EXP_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .div_in(div3), .clr_err(clr_err),
        .period_o(period3), .high_o(high3), .meas_valid(meas_valid3),
        .locked(locked3), .err_pulse(err_pulse3), .stuck(stuck3),
        .err_count(err_count3)
    );

    div_ratio_monitor #(.EXP_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .div_in(div4), .clr_err(clr_err),
        .period_o(period4), .high_o(high4), .meas_valid(meas_valid4),
        .locked(locked4), .err_pulse(err_pulse4), .stuck(stuck4),
        .err_count(err_count4)
    );

    // Ratio-3 source: high 2 / low 1, with an optional one-shot period shape.
    initial begin
        int hi, lo;
        div3 = 1'b0;
        forever begin
            if (gen_on) begin
                hi = 2;
                lo = 1;
                if (shot_req != shot_done) begin
                    hi = shot_hi;
                    lo = shot_lo;
                    shot_done++;
                end
                for (int i = 0; i < hi; i++) begin
                    @(posedge clk); #2;
                    if (div3 == 1'b0) begin
                        last_rise_edge = cyc;
                        rise_count++;
                    end
                    div3 = 1'b1;
                end
                for (int i = 0; i < lo; i++) begin
                    @(posedge clk); #2;
                    div3 = 1'b0;
                end
            end else begin
                @(posedge clk); #2;
                div3 = 1'b0;
            end
        end
    end

    // Ratio-4 source with 3/1 duty, which never satisfies the duty rule.
    initial begin
        div4 = 1'b0;
        repeat (2) @(posedge clk);
        forever begin
            repeat (3) begin @(posedge clk); #2; div4 = 1'b1; end
            @(posedge clk); #2;
            div4 = 1'b0;
        end
    end

    task automatic check_output(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_meas3(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (meas_valid3) begin
                ok = 1;
                break;
            end
        end
        check_output(tag, int'(ok), 1);
    endtask

    task automatic wait_meas4(input string tag, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (meas_valid4) begin
                ok = 1;
                break;
            end
        end
        check_output(tag, int'(ok), 1);
    endtask

    task automatic wait_bad_period(input string tag);
        for (int i = 0; i < 5; i++) begin
            wait_meas3(tag, 10);
            if (period3 != 16'd3) break;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_period"}, int'(period3), 0);
        check_output({tag, "_high"}, int'(high3), 0);
        check_output({tag, "_valid"}, int'(meas_valid3), 0);
        check_output({tag, "_locked"}, int'(locked3), 0);
        check_output({tag, "_errp"}, int'(err_pulse3), 0);
        check_output({tag, "_stuck"}, int'(stuck3), 0);
        check_output({tag, "_errc"}, int'(err_count3), 0);
    endtask

    task automatic relock(input string tag);
        for (int i = 0; i < 4; i++) begin
            wait_meas3({tag, "_meas"}, 10);
            check_output({tag, "_period"}, int'(period3), 3);
            check_output({tag, "_errp"}, int'(err_pulse3), 0);
        end
        check_output({tag, "_not_yet"}, int'(locked3), 0);
        tick();
        check_output({tag, "_locked"}, int'(locked3), 1);
    endtask

    initial begin
        int pulses;
        int stuck_edge;
        bit seen;

        rst = 1'b0;
        clr_err = 1'b0;
        #1;
        check_reset_outputs("reset");
        #9;
        rst = 1'b1;
        gen_on = 1'b1;

        $display("[TB] clean ratio-3 acquisition");
        wait_meas3("first_meas", 20);
        check_output("first_meas_rises", rise_count, 2);
        check_output("first_period", int'(period3), 3);
        check_output("first_high", int'(high3), 2);
        for (int i = 0; i < 3; i++) begin
            wait_meas3("acq_meas", 10);
            check_output("acq_period", int'(period3), 3);
            check_output("acq_high", int'(high3), 2);
            check_output("acq_unlocked", int'(locked3), 0);
        end
        tick();
        check_output("lock_after_4", int'(locked3), 1);
        check_output("lock_errc", int'(err_count3), 0);

        $display("[TB] single 4-cycle period while locked");
        shot_hi = 2;
        shot_lo = 2;
        shot_req++;
        wait_bad_period("bad_meas");
        check_output("bad_period", int'(period3), 4);
        check_output("bad_errp", int'(err_pulse3), 1);
        check_output("bad_errc", int'(err_count3), 1);
        tick();
        check_output("bad_errp_once", int'(err_pulse3), 0);
        check_output("bad_unlock", int'(locked3), 0);
        check_output("bad_errc_hold", int'(err_count3), 1);
        relock("relock1");

        $display("[TB] div_in held low while locked");
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check_output("clr_errc", int'(err_count3), 0);
        gen_on = 1'b0;
        pulses = 0;
        seen = 0;
        stuck_edge = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (err_pulse3) pulses++;
            if (stuck3) begin
                seen = 1;
                stuck_edge = cyc;
                break;
            end
        end
        check_output("stuck_seen", int'(seen), 1);
        check_output("stuck_delay", stuck_edge - last_rise_edge, 68);
        check_output("stuck_errp", int'(err_pulse3), 1);
        check_output("stuck_errc", int'(err_count3), 1);
        tick();
        check_output("stuck_unlock", int'(locked3), 0);
        check_output("stuck_hold", int'(stuck3), 1);
        for (int i = 0; i < 6; i++) begin
            if (err_pulse3) pulses++;
            tick();
        end
        check_output("stuck_pulses", pulses, 1);

        gen_on = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!stuck3) begin
                seen = 1;
                break;
            end
        end
        check_output("resume_clear", int'(seen), 1);
        check_output("resume_novalid0", int'(meas_valid3), 0);
        tick();
        check_output("resume_novalid1", int'(meas_valid3), 0);
        tick();
        check_output("resume_novalid2", int'(meas_valid3), 0);
        relock("relock2");

        $display("[TB] clear coinciding with locked mismatch");
        clr_err = 1'b1;
        shot_req++;
        wait_bad_period("clr_meas");
        check_output("clr_period", int'(period3), 4);
        check_output("clr_errp", int'(err_pulse3), 1);
        check_output("clr_wins", int'(err_count3), 0);
        clr_err = 1'b0;
        tick();
        check_output("clr_after", int'(err_count3), 0);
        relock("relock3");

        $display("[TB] ratio 4 with 3/1 duty");
        for (int i = 0; i < 5; i++) begin
            wait_meas4("r4_meas", 12);
            check_output("r4_period", int'(period4), 4);
            check_output("r4_high", int'(high4), 3);
        end
        check_output("r4_errc", int'(err_count4), 0);
        check_output("r4_never_locked", int'(locked4_seen), 0);

        $display("[TB] asynchronous reset while locked");
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #3;
            if (div3 == 1'b0) begin
                rst = 1'b1;
                seen = 1;
                break;
            end
        end
        check_output("rst_release", int'(seen), 1);
        wait_meas3("post_rst_meas", 20);
        check_output("post_rst_period", int'(period3), 3);
        check_output("post_rst_high", int'(high3), 2);
        for (int i = 0; i < 3; i++) begin
            wait_meas3("post_rst_acq", 10);
            check_output("post_rst_acq_period", int'(period3), 3);
        end
        tick();
        check_output("post_rst_locked", int'(locked3), 1);
        check_output("post_rst_errc", int'(err_count3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
